pattern_scan_ctrl: RTL and testbench

//  Sequencer for a shared serial Moore pattern detector (ports a in, y out).

---
 rtl/pattern_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that feeds parallel words bit-serially into a shared Moore pattern
// detector and reports how many times it fired and where it fired first.
module pattern_scan_ctrl #(
    parameter int unsigned  WIDTH     = 8,
    parameter bit           MSB_FIRST = 1'b1,
    localparam int unsigned CW        = $clog2(WIDTH + 1),
    localparam int unsigned IW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             det_clr,
    output logic             det_a,
    input  logic             det_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    match_cnt,
    output logic [IW-1:0]    first_idx,
    output logic             first_hit,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    pos_q;
    logic [IW-1:0]    pos_d;
    logic [WIDTH-1:0] word_q;
    logic             accept;
    logic             sample;
    logic [IW-1:0]    rpos;
    logic [IW-1:0]    bidx;
    logic             next_a;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    // Next state, capture strobe and detector-response sampling
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        accept  = 1'b0;
        sample  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                pos_d   = '0;
            end
            SHIFT: begin
                // det_y lags det_a by one edge, so bit 0 has no response yet
                sample = (pos_q != '0);
                if (pos_q == IW'(WIDTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    pos_d = pos_q + IW'(1);
                end
            end
            DRAIN: begin
                sample  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            sample  = 1'b0;
        end
    end

    // Response position of the current sample and the bit to present next cycle
    always_comb begin
        rpos   = (state_q == DRAIN) ? IW'(WIDTH - 1) : (pos_q - IW'(1));
        bidx   = MSB_FIRST ? (IW'(WIDTH - 1) - pos_d) : pos_d;
        next_a = (state_d == SHIFT) ? word_q[bidx] : 1'b0;
    end

    // Registered outputs derived from the upcoming state, plus result accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            det_clr   <= 1'b0;
            det_a     <= 1'b0;
            out_valid <= 1'b0;
            word_q    <= '0;
            match_cnt <= '0;
            first_idx <= '0;
            first_hit <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            det_clr   <= (state_d == CLEAR);
            det_a     <= next_a;
            out_valid <= (state_d == DONE);
            if (accept) begin
                word_q    <= in_data;
                match_cnt <= '0;
                first_idx <= '0;
                first_hit <= 1'b0;
            end else if (sample && det_y) begin
                match_cnt <= match_cnt + CW'(1);
                if (!first_hit) begin
                    first_idx <= rpos;
                    first_hit <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: MSB-first and LSB-first instances run in lockstep,
// each driving its own overlapping "101" Moore detector model.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       abort;
    logic       out_ready;

    logic       in_ready_m, det_clr_m, det_a_m, det_y_m, out_valid_m, first_hit_m, busy_m;
    logic [3:0] match_cnt_m;
    logic [2:0] first_idx_m;
    logic       in_ready_l, det_clr_l, det_a_l, det_y_l, out_valid_l, first_hit_l, busy_l;
    logic [3:0] match_cnt_l;
    logic [2:0] first_idx_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .abort(abort), .det_clr(det_clr_m), .det_a(det_a_m),
        .det_y(det_y_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .match_cnt(match_cnt_m), .first_idx(first_idx_m), .first_hit(first_hit_m),
        .busy(busy_m)
    );

    pattern_scan_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .abort(abort), .det_clr(det_clr_l), .det_a(det_a_l),
        .det_y(det_y_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .match_cnt(match_cnt_l), .first_idx(first_idx_l), .first_hit(first_hit_l),
        .busy(busy_l)
    );

    // Detector model: 0=S0, 1=S1, 2=S10, 3=S101; only det_clr returns it to S0
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic a);
        case (s)
            2'd0:    return a ? 2'd1 : 2'd0;
            2'd1:    return a ? 2'd1 : 2'd2;
            2'd2:    return a ? 2'd3 : 2'd0;
            default: return a ? 2'd1 : 2'd2;
        endcase
    endfunction

    logic [1:0] ds_m = 2'd0;
    logic [1:0] ds_l = 2'd0;
    always @(posedge clk) ds_m <= det_clr_m ? 2'd0 : det_next(ds_m, det_a_m);
    always @(posedge clk) ds_l <= det_clr_l ? 2'd0 : det_next(ds_l, det_a_l);
    assign det_y_m = (ds_m == 2'd3);
    assign det_y_l = (ds_l == 2'd3);

    typedef struct {
        logic [7:0] data;
        bit         abort_idle;
        int         hold;
        logic [3:0] cnt_m;
        logic       hit_m;
        logic [2:0] idx_m;
        logic [3:0] cnt_l;
        logic       hit_l;
        logic [2:0] idx_l;
    } vec_t;

    typedef struct {
        logic [7:0] res_m;
        logic [7:0] res_l;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard: pop and compare whenever a result handshake is about to complete
    always @(negedge clk) begin
        if (reset && out_valid_m && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_msb", {24'd0, match_cnt_m, first_hit_m, first_idx_m}, {24'd0, e.res_m});
                chk("result_lsb", {24'd0, out_valid_l, match_cnt_l, first_hit_l, first_idx_l},
                    {24'd0, 1'b1, e.res_l});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready_m && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Offer one word, time its result, optionally stall the consumer
    task automatic send(input vec_t v);
        int n;
        exp_t e;
        wait_ready();
        in_valid  = 1'b1;
        in_data   = v.data;
        abort     = v.abort_idle;
        out_ready = (v.hold == 0);
        @(posedge clk);
        e.res_m = {v.cnt_m, v.hit_m, v.idx_m};
        e.res_l = {v.cnt_l, v.hit_l, v.idx_l};
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        n = 0;
        while (!out_valid_m && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd10);
        chk("done_flags", {28'd0, out_valid_l, in_ready_m, in_ready_l, busy_m}, {28'd0, 4'b1001});
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", {22'd0, out_valid_m, in_ready_m, match_cnt_m, first_hit_m, first_idx_m},
                {22'd0, 1'b1, 1'b0, v.cnt_m, v.hit_m, v.idx_m});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_to_idle", {29'd0, out_valid_m, in_ready_m, busy_m}, {29'd0, 3'b010});
    endtask

    initial begin
        tbl[0] = '{8'b1010_1000, 1'b0, 0, 4'd2, 1'b1, 3'd2, 4'd2, 1'b1, 3'd5};
        tbl[1] = '{8'h00,        1'b0, 0, 4'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0};
        tbl[2] = '{8'b1010_1010, 1'b0, 5, 4'd3, 1'b1, 3'd2, 4'd3, 1'b1, 3'd3};
        tbl[3] = '{8'hFF,        1'b1, 0, 4'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0};
        tbl[4] = '{8'b0000_0101, 1'b0, 0, 4'd1, 1'b1, 3'd7, 4'd1, 1'b1, 3'd2};
        tbl[5] = '{8'b1011_0101, 1'b0, 2, 4'd3, 1'b1, 3'd2, 4'd3, 1'b1, 3'd2};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {6'd0, in_ready_m, det_clr_m, det_a_m, out_valid_m, match_cnt_m, first_idx_m, first_hit_m, busy_m,
                   in_ready_l, det_clr_l, det_a_l, out_valid_l, match_cnt_l, first_idx_l, first_hit_l, busy_l},
            32'd0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) send(tbl[i]);

        // Abort during SHIFT at p=4: accept edge T, abort sampled at edge T+6
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'b1010_1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_abort_busy", {31'd0, busy_m}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {28'd0, busy_m, in_ready_m, out_valid_m, busy_l}, {28'd0, 4'b0100});
        chk("abort_partial", {24'd0, match_cnt_m, first_hit_m, first_idx_m}, {24'd0, 4'd1, 1'b1, 3'd2});
        begin
            int seen = 0;
            for (int i = 0; i < 14; i++) begin
                @(posedge clk); #1;
                if (out_valid_m || out_valid_l) seen++;
            end
            chk("abort_no_valid", 32'(seen), 32'd0);
        end
        send(tbl[0]);

        // Asynchronous reset in the middle of SHIFT
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'b1010_1010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midscan_reset",
            {6'd0, in_ready_m, det_clr_m, det_a_m, out_valid_m, match_cnt_m, first_idx_m, first_hit_m, busy_m,
                   in_ready_l, det_clr_l, det_a_l, out_valid_l, match_cnt_l, first_idx_l, first_hit_l, busy_l},
            32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send(tbl[0]);
        send(tbl[4]);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
